// File: rtl/axi_adapter_arb_if.sv
// axi_adapter_arb_if
// Bundles the requester-side and adapter-side signals of the arbiter.
//
// Requester side, one entry per port:
//   req, req_type (0 = SINGLE_REQ, 1 = cache-line request), addr, we, wdata,
//   be and size come in.
//   gnt, valid and critical_word_valid go out as one-hot strobes.
//   rdata and critical_word are shared by all ports.
// Adapter side:
//   adp_req, adp_type, adp_addr, adp_we, adp_wdata, adp_be, adp_size and
//   adp_id go out.
//   adp_gnt, adp_valid, adp_rdata, adp_rsp_id (completion ID), adp_cw and
//   adp_cw_valid come in.
// err is the sticky protocol-error flag.
// The arbiter uses the slave modport; the environment uses the master modport.
interface axi_adapter_arb_if #(
  parameter int NR_PORTS     = 3,
  parameter int DATA_WIDTH   = 256,
  parameter int AXI_ID_WIDTH = 10
);
  logic [NR_PORTS-1:0]                   req;
  logic [NR_PORTS-1:0]                   req_type;
  logic [NR_PORTS-1:0][63:0]             addr;
  logic [NR_PORTS-1:0]                   we;
  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]   wdata;
  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0] be;
  logic [NR_PORTS-1:0][1:0]              size;
  logic [NR_PORTS-1:0]                   gnt;
  logic [NR_PORTS-1:0]                   valid;
  logic [DATA_WIDTH-1:0]                 rdata;
  logic [63:0]                           critical_word;
  logic [NR_PORTS-1:0]                   critical_word_valid;

  logic                                  adp_req;
  logic                                  adp_type;
  logic [63:0]                           adp_addr;
  logic                                  adp_we;
  logic [DATA_WIDTH-1:0]                 adp_wdata;
  logic [DATA_WIDTH/8-1:0]               adp_be;
  logic [1:0]                            adp_size;
  logic [AXI_ID_WIDTH-1:0]               adp_id;
  logic                                  adp_gnt;
  logic                                  adp_valid;
  logic [DATA_WIDTH-1:0]                 adp_rdata;
  logic [AXI_ID_WIDTH-1:0]               adp_rsp_id;
  logic [63:0]                           adp_cw;
  logic                                  adp_cw_valid;

  logic                                  err;

  modport slave (
    input  req, req_type, addr, we, wdata, be, size,
    output gnt, valid, rdata, critical_word, critical_word_valid,
    output adp_req, adp_type, adp_addr, adp_we, adp_wdata, adp_be, adp_size, adp_id,
    input  adp_gnt, adp_valid, adp_rdata, adp_rsp_id, adp_cw, adp_cw_valid,
    output err
  );

  modport master (
    output req, req_type, addr, we, wdata, be, size,
    input  gnt, valid, rdata, critical_word, critical_word_valid,
    input  adp_req, adp_type, adp_addr, adp_we, adp_wdata, adp_be, adp_size, adp_id,
    output adp_gnt, adp_valid, adp_rdata, adp_rsp_id, adp_cw, adp_cw_valid,
    input  err
  );
endinterface

// File: rtl/axi_adapter_arb.sv
// axi_adapter_arb
// Round-robin arbiter that shares one AXI adapter request port among
// NR_PORTS cache-side requesters. Only one transaction is outstanding at a
// time. The winning port index is used as the transaction ID. Grant, critical
// word and completion are routed back to the port that owns the transaction.
//
// Ports:
//   clk  clock
//   rst  synchronous reset, active-high
//   bus  axi_adapter_arb_if.slave, holding the requester-side and
//        adapter-side signals
module axi_adapter_arb #(
  parameter int NR_PORTS     = 3,
  parameter int DATA_WIDTH   = 256,
  parameter int AXI_ID_WIDTH = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  axi_adapter_arb_if.slave     bus
);
  localparam int SEL_W = $clog2(NR_PORTS);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RESP = 2'd2
  } state_t;

  state_t           state_q, state_d, cur_state;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic [SEL_W-1:0] rr_q, rr_d;
  logic [SEL_W-1:0] winner;
  logic [SEL_W-1:0] sel_next;
  logic             err_q, err_d;

  // Read data and the critical word pass straight through.
  // A port only looks at them while its own strobe is high.
  assign bus.rdata         = bus.adp_rdata;
  assign bus.critical_word = bus.adp_cw;
  assign bus.err           = err_q & ~rst;

  // Round-robin pointer value that follows the current owner.
  assign sel_next = (sel_q == SEL_W'(NR_PORTS - 1)) ? '0 : sel_q + 1'b1;

  // Round-robin search: offsets are scanned from the highest to the lowest.
  // The last hit therefore belongs to the first requesting port at or above rr_q.
  always_comb begin
    int cand;
    cand   = 0;
    winner = rr_q;
    for (int i = NR_PORTS - 1; i >= 0; i--) begin
      cand = (int'(rr_q) + i) % NR_PORTS;
      if (bus.req[cand]) winner = SEL_W'(cand);
    end
  end

  // While reset is asserted, the output logic decodes as IDLE.
  // This forces every strobe to 0 during reset as well as after it.
  assign cur_state = rst ? IDLE : state_q;

  // Next-state and output decode.
  // Adapter fields stay zero outside ISSUE.
  // Strobes back to the ports are one-hot on sel_q.
  always_comb begin
    state_d                 = cur_state;
    sel_d                   = sel_q;
    rr_d                    = rr_q;
    err_d                   = err_q;
    bus.gnt                 = '0;
    bus.valid               = '0;
    bus.critical_word_valid = '0;
    bus.adp_req             = 1'b0;
    bus.adp_type            = 1'b0;
    bus.adp_addr            = '0;
    bus.adp_we              = 1'b0;
    bus.adp_wdata           = '0;
    bus.adp_be              = '0;
    bus.adp_size            = '0;
    bus.adp_id              = '0;
    case (cur_state)
      IDLE: begin
        if (|bus.req) begin
          sel_d   = winner;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        bus.adp_req   = 1'b1;
        bus.adp_type  = bus.req_type[sel_q];
        bus.adp_addr  = bus.addr[sel_q];
        bus.adp_we    = bus.we[sel_q];
        bus.adp_wdata = bus.wdata[sel_q];
        bus.adp_be    = bus.be[sel_q];
        bus.adp_size  = bus.size[sel_q];
        bus.adp_id    = AXI_ID_WIDTH'(sel_q);
        if (bus.adp_gnt) begin
          bus.gnt[sel_q] = 1'b1;
          rr_d           = sel_next;
          state_d        = WAIT_RESP;
          if (bus.adp_valid) begin
            bus.valid[sel_q] = 1'b1;
            state_d          = IDLE;
            if (bus.adp_rsp_id != AXI_ID_WIDTH'(sel_q)) err_d = 1'b1;
          end
        end else if (!bus.req[sel_q]) begin
          err_d = 1'b1;
        end
      end
      WAIT_RESP: begin
        bus.critical_word_valid[sel_q] = bus.adp_cw_valid;
        if (bus.adp_valid) begin
          bus.valid[sel_q] = 1'b1;
          state_d          = IDLE;
          if (bus.adp_rsp_id != AXI_ID_WIDTH'(sel_q)) err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  // Reset discards any in-flight transaction and clears the sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_axi_adapter_arb.sv
// tb_axi_adapter_arb
// Directed bench for axi_adapter_arb with NR_PORTS=3, DATA_WIDTH=256 and
// AXI_ID_WIDTH=10.
// Inputs change 1 ns after each rising clock edge.
// Outputs are compared 2 ns after the edge, once combinational paths settle.
module tb_axi_adapter_arb;
  localparam int NR_PORTS     = 3;
  localparam int DATA_WIDTH   = 256;
  localparam int AXI_ID_WIDTH = 10;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  axi_adapter_arb_if #(
    .NR_PORTS(NR_PORTS), .DATA_WIDTH(DATA_WIDTH), .AXI_ID_WIDTH(AXI_ID_WIDTH)
  ) bus ();

  axi_adapter_arb #(
    .NR_PORTS(NR_PORTS), .DATA_WIDTH(DATA_WIDTH), .AXI_ID_WIDTH(AXI_ID_WIDTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the per-cycle control inputs, then let combinational outputs settle.
  task automatic applyStimulus(input logic [2:0] req, input logic gnt, input logic vld,
                               input logic cw_vld, input logic [9:0] rsp_id);
    bus.req          = req;
    bus.adp_gnt      = gnt;
    bus.adp_valid    = vld;
    bus.adp_cw_valid = cw_vld;
    bus.adp_rsp_id   = rsp_id;
    #1;
  endtask

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Directed sequence covering reset, arbitration order, delayed handshakes,
  // protocol errors and reset during a transaction.
  initial begin
    logic [255:0] line_a5;
    logic [255:0] wline;
    line_a5 = {8{32'hA5A5_A5A5}};
    wline   = {4{64'h0123_4567_89AB_CDEF}};

    rst          = 1'b1;
    bus.req_type = '0;
    bus.addr     = '0;
    bus.we       = '0;
    bus.wdata    = '0;
    bus.be       = '0;
    bus.size     = '0;
    bus.adp_rdata = '0;
    bus.adp_cw   = '0;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("rst_adp_req", bus.adp_req, 1'b0);
    checkOutput("rst_gnt", bus.gnt, 3'b000);
    checkOutput("rst_valid", bus.valid, 3'b000);
    checkOutput("rst_err", bus.err, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Single cache-line read from port 1.
    $display("[TB] single read port 1");
    bus.addr[1]     = 64'h0000_0000_8000_0040;
    bus.req_type[1] = 1'b1;
    bus.we[1]       = 1'b0;
    bus.size[1]     = 2'd3;
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t1_no_same_cycle_issue", bus.adp_req, 1'b0);
    tick();
    applyStimulus(3'b010, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t1_adp_req", bus.adp_req, 1'b1);
    checkOutput("t1_adp_id", bus.adp_id, 10'd1);
    checkOutput("t1_adp_addr", bus.adp_addr, 64'h8000_0040);
    checkOutput("t1_adp_type", bus.adp_type, 1'b1);
    checkOutput("t1_gnt_before", bus.gnt, 3'b000);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("t1_gnt", bus.gnt, 3'b010);
    tick();
    bus.adp_cw = 64'hDEAD_BEEF_0123_4567;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 10'd0);
    checkOutput("t1_wait_no_req", bus.adp_req, 1'b0);
    checkOutput("t1_cw_valid", bus.critical_word_valid, 3'b010);
    checkOutput("t1_cw", bus.critical_word, 64'hDEAD_BEEF_0123_4567);
    tick();
    bus.adp_rdata = line_a5;
    applyStimulus(3'b000, 1'b0, 1'b1, 1'b0, 10'd1);
    checkOutput("t1_valid", bus.valid, 3'b010);
    checkOutput("t1_rdata", bus.rdata, line_a5);
    checkOutput("t1_cw_valid_off", bus.critical_word_valid, 3'b000);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t1_valid_after", bus.valid, 3'b000);
    checkOutput("t1_err", bus.err, 1'b0);

    // All ports request continuously; the adapter grants and completes at once.
    $display("[TB] round robin back-to-back");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(3'b111, 1'b1, 1'b1, 1'b0, 10'd0);
    for (int k = 0; k < 5; k++) begin
      checkOutput("t2_idle_gap", bus.adp_req, 1'b0);
      checkOutput("t2_idle_valid", bus.valid, 3'b000);
      tick();
      applyStimulus(3'b111, 1'b1, 1'b1, 1'b0, 10'(k % 3));
      checkOutput("t2_issue", bus.adp_req, 1'b1);
      checkOutput("t2_id", bus.adp_id, 10'(k % 3));
      checkOutput("t2_gnt", bus.gnt, 3'b001 << (k % 3));
      checkOutput("t2_valid", bus.valid, 3'b001 << (k % 3));
      tick();
      applyStimulus(3'b111, 1'b1, 1'b1, 1'b0, 10'd0);
    end
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t2_err", bus.err, 1'b0);

    // Port 2 write: grant arrives 3 cycles late, completion 2 cycles later.
    $display("[TB] delayed write port 2");
    bus.addr[2]     = 64'h0000_0000_0000_1000;
    bus.req_type[2] = 1'b0;
    bus.we[2]       = 1'b1;
    bus.wdata[2]    = wline;
    bus.be[2]       = 32'hFFFF_FFFF;
    bus.size[2]     = 2'd3;
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t3_idle", bus.adp_req, 1'b0);
    tick();
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t3_adp_req", bus.adp_req, 1'b1);
    checkOutput("t3_adp_id", bus.adp_id, 10'd2);
    checkOutput("t3_adp_we", bus.adp_we, 1'b1);
    checkOutput("t3_adp_wdata", bus.adp_wdata, wline);
    checkOutput("t3_adp_be", bus.adp_be, 32'hFFFF_FFFF);
    checkOutput("t3_gnt_early0", bus.gnt, 3'b000);
    for (int c = 1; c < 3; c++) begin
      tick();
      applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("t3_gnt_early", bus.gnt, 3'b000);
      checkOutput("t3_req_held", bus.adp_req, 1'b1);
    end
    tick();
    applyStimulus(3'b100, 1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("t3_gnt", bus.gnt, 3'b100);
    for (int c = 0; c < 2; c++) begin
      tick();
      applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 10'd0);
      checkOutput("t3_wait_no_req", bus.adp_req, 1'b0);
      checkOutput("t3_wait_no_gnt", bus.gnt, 3'b000);
      checkOutput("t3_wait_no_valid", bus.valid, 3'b000);
    end
    tick();
    applyStimulus(3'b001, 1'b0, 1'b1, 1'b0, 10'd2);
    checkOutput("t3_valid", bus.valid, 3'b100);
    checkOutput("t3_valid_no_gnt", bus.gnt, 3'b000);

    // Port 0 was held off during the write. Its completion now carries the wrong ID.
    $display("[TB] completion id mismatch");
    tick();
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t4_idle", bus.adp_req, 1'b0);
    tick();
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("t4_adp_id", bus.adp_id, 10'd0);
    checkOutput("t4_gnt", bus.gnt, 3'b001);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b1, 1'b0, 10'd2);
    checkOutput("t4_valid", bus.valid, 3'b001);
    checkOutput("t4_err_not_yet", bus.err, 1'b0);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t4_err", bus.err, 1'b1);
    checkOutput("t4_valid_after", bus.valid, 3'b000);
    tick();
    tick();
    checkOutput("t4_err_sticky", bus.err, 1'b1);

    // Port 0 drops its request while in ISSUE.
    $display("[TB] request dropped before grant");
    rst = 1'b1;
    tick();
    rst = 1'b0;
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t5_err_cleared", bus.err, 1'b0);
    tick();
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t5_issue", bus.adp_req, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t5_err_same_cycle", bus.err, 1'b0);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t5_err", bus.err, 1'b1);
    checkOutput("t5_req_stays", bus.adp_req, 1'b1);
    applyStimulus(3'b001, 1'b1, 1'b1, 1'b0, 10'd0);
    checkOutput("t5_gnt", bus.gnt, 3'b001);
    checkOutput("t5_valid", bus.valid, 3'b001);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t5_idle", bus.adp_req, 1'b0);

    // Reset asserted during WAIT_RESP.
    $display("[TB] reset mid-transaction");
    applyStimulus(3'b001, 1'b0, 1'b0, 1'b0, 10'd0);
    tick();
    applyStimulus(3'b001, 1'b1, 1'b0, 1'b0, 10'd0);
    checkOutput("t6_gnt", bus.gnt, 3'b001);
    tick();
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 10'd0);
    checkOutput("t6_cw_valid", bus.critical_word_valid, 3'b001);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_cw_valid", bus.critical_word_valid, 3'b000);
    checkOutput("t6_rst_err", bus.err, 1'b0);
    checkOutput("t6_rst_rdata", bus.rdata, line_a5);
    tick();
    rst = 1'b0;
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t6_post_req", bus.adp_req, 1'b0);
    checkOutput("t6_post_valid", bus.valid, 3'b000);
    checkOutput("t6_post_err", bus.err, 1'b0);
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t6_idle", bus.adp_req, 1'b0);
    tick();
    applyStimulus(3'b100, 1'b0, 1'b0, 1'b0, 10'd0);
    checkOutput("t6_issue", bus.adp_req, 1'b1);
    checkOutput("t6_adp_id", bus.adp_id, 10'd2);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 10'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
